// File: rtl/nn_sw_pkg.sv
// Shared types and defaults for the switch conditioner.
// Debounce FSM state encoding and a counter-width helper.
// No flow control; combinational definitions only.
package nn_sw_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } sw_state_t;

  localparam int DEF_NUM_SW          = 6;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_LOCKOUT_CYCLES  = 256;
  localparam int DEF_VALID_IDX       = 0;
  localparam int DEF_LONG_CYCLES     = 50000;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_sw_debounce.sv
// One switch channel: 2-flop synchroniser, debounce FSM, optional long-press (NN_SW_LONGPRESS_EN).
// Level/edge outputs registered, DEBOUNCE_CYCLES+3 edges after a stable pin change.
// No backpressure; pulses are single-cycle and never held.
module nn_sw_debounce
  import nn_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          q1;
  logic          q2;
  sw_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1    <= 1'b0;
      q2    <= 1'b0;
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      q1   <= sw_raw;
      q2   <= q1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: begin
          if (q2) begin
            state <= WAIT_HI;
            cnt   <= '0;
          end
        end
        WAIT_HI: begin
          // Any low sample falls back to the stable state, restarting the count.
          if (!q2) begin
            state <= ST_LO;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HI: begin
          if (!q2) begin
            state <= WAIT_LO;
            cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (q2) begin
            state <= ST_HI;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_LO;
      endcase
    end
  end

`ifdef NN_SW_LONGPRESS_EN
  localparam int            LW        = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold_cnt;
  logic          hold_done;

  // level is high exactly in ST_HI/WAIT_LO, so it gates the hold count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!level) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (!hold_done) begin
        if (hold_cnt == HOLD_LAST) begin
          long_press <= 1'b1;
          hold_done  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/nn_switch_conditioner.sv
// Conditions io_in[37:32] switches into debounced levels/edges and a locked-out in_valid pulse (NN_SW_LONGPRESS_EN adds long-press).
// Levels/edges DEBOUNCE_CYCLES+3 edges after a stable pin change; in_valid_o one cycle after the rise.
// No backpressure; a rise suppressed by lockout is dropped, not queued.
module nn_switch_conditioner
  import nn_sw_pkg::*;
#(
  parameter int NUM_SW          = DEF_NUM_SW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int VALID_IDX       = DEF_VALID_IDX,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [NUM_SW-1:0] sw_level_o,
  output logic [NUM_SW-1:0] sw_rise_o,
  output logic [NUM_SW-1:0] sw_fall_o,
  output logic              in_valid_o,
  output logic              lockout_o,
  output logic [NUM_SW-1:0] sw_long_o
);

  localparam int             LCW       = cnt_width(LOCKOUT_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCKOUT_CYCLES);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    nn_sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_debounce (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .sw_raw     (sw_raw_i[g]),
      .level      (sw_level_o[g]),
      .rise       (sw_rise_o[g]),
      .fall       (sw_fall_o[g]),
      .long_press (sw_long_o[g])
    );
  end

  logic [LCW-1:0] lock_cnt;
  logic           fire;

  // A rise seen in the cycle lock_cnt has just reached zero is accepted.
  assign fire      = sw_rise_o[VALID_IDX] && (lock_cnt == '0);
  assign lockout_o = (lock_cnt != '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lock_cnt   <= '0;
      in_valid_o <= 1'b0;
    end else begin
      in_valid_o <= fire;
      if (fire) begin
        lock_cnt <= LOCK_LOAD;
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_switch_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events by cycle, a negedge monitor pops and compares.
// A second instance with a longer lockout lets a re-press on the valid channel land inside the window.
module tb_nn_switch_conditioner;

  localparam int NSW = 6;
  localparam int DB  = 4;
  localparam int LK  = 8;
  localparam int LKB = 21;
  localparam int LG  = 20;

  localparam int K_RISE    = 0;
  localparam int K_FALL    = 1;
  localparam int K_LONG    = 2;
  localparam int K_VALID   = 3;
  localparam int K_LKON    = 4;
  localparam int K_LKOFF   = 5;
  localparam int K_VALID_B = 6;
  localparam int K_LKON_B  = 7;
  localparam int K_LKOFF_B = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSW-1:0] sw_raw = '0;

  logic [NSW-1:0] sw_level, sw_rise, sw_fall, sw_long;
  logic           in_valid, lockout;
  logic [NSW-1:0] b_level, b_rise, b_fall, b_long;
  logic           b_in_valid, b_lockout;

  nn_switch_conditioner #(
    .NUM_SW(NSW), .DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LK), .VALID_IDX(0), .LONG_CYCLES(LG)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sw_raw_i(sw_raw),
    .sw_level_o(sw_level), .sw_rise_o(sw_rise), .sw_fall_o(sw_fall),
    .in_valid_o(in_valid), .lockout_o(lockout), .sw_long_o(sw_long)
  );

  nn_switch_conditioner #(
    .NUM_SW(NSW), .DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LKB), .VALID_IDX(0), .LONG_CYCLES(LG)
  ) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .sw_raw_i(sw_raw),
    .sw_level_o(b_level), .sw_rise_o(b_rise), .sw_fall_o(b_fall),
    .in_valid_o(b_in_valid), .lockout_o(b_lockout), .sw_long_o(b_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t exp_q[$];

  function automatic int key(input ev_t e);
    return e.cyc * 100 + e.kind * 10 + e.ch;
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_RISE:    return "rise";
      K_FALL:    return "fall";
      K_LONG:    return "long";
      K_VALID:   return "in_valid";
      K_LKON:    return "lockout_on";
      K_LKOFF:   return "lockout_off";
      K_VALID_B: return "in_valid_b";
      K_LKON_B:  return "lockout_on_b";
      K_LKOFF_B: return "lockout_off_b";
      default:   return "unknown";
    endcase
  endfunction

  task automatic expect_ev(input int c, input int k, input int ch);
    ev_t e;
    int  i;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    i = 0;
    while (i < exp_q.size() && key(exp_q[i]) <= key(e)) i++;
    exp_q.insert(i, e);
  endtask

  task automatic observe(input int k, input int ch);
    ev_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.ch   = ch;
    checks++;
    if (exp_q.size() > 0 && key(exp_q[0]) == key(e)) begin
      exp_q.delete(0);
      if (k == K_RISE || k == K_FALL) begin
        checks++;
        if (sw_level[ch] !== (k == K_RISE)) begin
          failures++;
          $display("FAIL level_on_%s ch%0d cycle %0d: got %b, want %b",
                   kname(k), ch, cyc, sw_level[ch], (k == K_RISE));
        end
      end
    end else begin
      failures++;
      if (exp_q.size() > 0)
        $display("FAIL unexpected_%s ch%0d at cycle %0d: next expected %s ch%0d at cycle %0d",
                 kname(k), ch, cyc, kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      else
        $display("FAIL unexpected_%s ch%0d at cycle %0d: nothing expected", kname(k), ch, cyc);
    end
  endtask

  logic prev_lk   = 1'b0;
  logic prev_lk_b = 1'b0;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_%s ch%0d: not observed, required at cycle %0d",
               kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      exp_q.delete(0);
    end
    for (int ch = 0; ch < NSW; ch++) if (sw_rise[ch] === 1'b1) observe(K_RISE, ch);
    for (int ch = 0; ch < NSW; ch++) if (sw_fall[ch] === 1'b1) observe(K_FALL, ch);
    for (int ch = 0; ch < NSW; ch++) if (sw_long[ch] === 1'b1) observe(K_LONG, ch);
    if (in_valid === 1'b1) observe(K_VALID, 0);
    if (lockout === 1'b1 && !prev_lk) observe(K_LKON, 0);
    if (lockout === 1'b0 && prev_lk) observe(K_LKOFF, 0);
    if (b_in_valid === 1'b1) observe(K_VALID_B, 0);
    if (b_lockout === 1'b1 && !prev_lk_b) observe(K_LKON_B, 0);
    if (b_lockout === 1'b0 && prev_lk_b) observe(K_LKOFF_B, 0);
    prev_lk   = (lockout === 1'b1);
    prev_lk_b = (b_lockout === 1'b1);
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    logic [63:0] all;
    all = {sw_level, sw_rise, sw_fall, sw_long, in_valid, lockout,
           b_level, b_rise, b_fall, b_long, b_in_valid, b_lockout};
    checks++;
    if (all !== 64'd0) begin
      failures++;
      $display("FAIL %s cycle %0d: outputs 0x%0h, want 0", name, cyc, all);
    end
  endtask

  // Pin changes applied just after edge T become visible after edge T+DB+3.
  localparam int LAT = DB + 3;

  task automatic push_valid(input int r, input bit acc_a, input bit acc_b);
    if (acc_a) begin
      expect_ev(r + 1, K_VALID, 0);
      expect_ev(r + 1, K_LKON, 0);
      expect_ev(r + 1 + LK, K_LKOFF, 0);
    end
    if (acc_b) begin
      expect_ev(r + 1, K_VALID_B, 0);
      expect_ev(r + 1, K_LKON_B, 0);
      expect_ev(r + 1 + LKB, K_LKOFF_B, 0);
    end
  endtask

  task automatic push_long(input int r, input int ch);
`ifdef NN_SW_LONGPRESS_EN
    expect_ev(r + LG, K_LONG, ch);
`else
    if (r < 0 || ch < 0) $display("note: bad long-press arguments");
`endif
  endtask

  initial begin
    // Reset state
    for (int c = 1; c <= 4; c++) begin
      at_cyc(c);
      check_zero("reset_outputs");
    end
    rst = 1'b0;

    // Clean press, long hold, release
    at_cyc(10);
    sw_raw[0] = 1'b1;
    expect_ev(10 + LAT, K_RISE, 0);
    push_valid(10 + LAT, 1'b1, 1'b1);
    push_long(10 + LAT, 0);
    at_cyc(30);
    check_val("level_held", int'(sw_level), 6'h01);
    at_cyc(50);
    sw_raw[0] = 1'b0;
    expect_ev(50 + LAT, K_FALL, 0);

    // Fast re-presses: second lands inside the long lockout only
    at_cyc(60);
    sw_raw[0] = 1'b1;
    expect_ev(67, K_RISE, 0);
    push_valid(67, 1'b1, 1'b1);
    at_cyc(65);
    sw_raw[0] = 1'b0;
    expect_ev(72, K_FALL, 0);
    at_cyc(71);
    sw_raw[0] = 1'b1;
    expect_ev(78, K_RISE, 0);
    push_valid(78, 1'b1, 1'b0);
    at_cyc(76);
    sw_raw[0] = 1'b0;
    expect_ev(83, K_FALL, 0);
    at_cyc(80);
    check_val("lockout_b_mid", int'(b_lockout), 1);
    // Third rise arrives exactly as the long lockout reaches zero
    at_cyc(82);
    sw_raw[0] = 1'b1;
    expect_ev(89, K_RISE, 0);
    push_valid(89, 1'b1, 1'b1);
    at_cyc(100);
    sw_raw[0] = 1'b0;
    expect_ev(107, K_FALL, 0);

    // Glitches of 3 and 4 cycles are rejected
    at_cyc(120);
    sw_raw[0] = 1'b1;
    sw_raw[2] = 1'b1;
    at_cyc(123);
    sw_raw[0] = 1'b0;
    at_cyc(124);
    sw_raw[2] = 1'b0;
    at_cyc(135);
    check_val("level_after_glitch", int'(sw_level), 0);

    // All channels together
    at_cyc(140);
    sw_raw = 6'h3F;
    for (int ch = 0; ch < NSW; ch++) begin
      expect_ev(147, K_RISE, ch);
      push_long(147, ch);
    end
    push_valid(147, 1'b1, 1'b1);
    at_cyc(180);
    sw_raw = 6'h01;
    for (int ch = 1; ch < NSW; ch++) expect_ev(187, K_FALL, ch);
    at_cyc(190);
    check_val("level_partial_release", int'(sw_level), 6'h01);

    // Reset during WAIT_HI with cnt=2 on ch3, ch0 held through
    at_cyc(200);
    sw_raw[3] = 1'b1;
    at_cyc(205);
    rst = 1'b1;
    for (int c = 206; c <= 209; c++) begin
      at_cyc(c);
      check_zero("mid_reset_outputs");
    end
    rst = 1'b0;
    expect_ev(209 + LAT, K_RISE, 0);
    expect_ev(209 + LAT, K_RISE, 3);
    push_valid(209 + LAT, 1'b1, 1'b1);
    push_long(209 + LAT, 0);
    push_long(209 + LAT, 3);
    at_cyc(230);
    check_val("level_after_reset", int'(sw_level), 6'h09);
    at_cyc(250);
    sw_raw = '0;
    expect_ev(257, K_FALL, 0);
    expect_ev(257, K_FALL, 3);
    at_cyc(270);
    check_val("level_final", int'(sw_level), 0);
    check_val("lockout_final", int'(lockout), 0);

    at_cyc(280);
    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL missing_%s ch%0d: not observed, required at cycle %0d",
               kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      exp_q.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_switch_conditioner.md
Name: nn_switch_conditioner

Overview:
- Upstream input stage for the NN accelerator.
- Conditions the raw user switch pins io_in[37:32] into clean, glitch-free levels and single-cycle edge pulses.
- Per switch: 2-flop synchroniser, then a debounce FSM.
- in_valid_o replaces the raw io_in[32] as the NN's in_valid_user source, with a post-pulse lockout window against repeated triggers.

Parameters:
- NUM_SW, 6: number of switch channels; channel i maps to io_in[32+i].
- DEBOUNCE_CYCLES, 1000: cycles the synchronised input must stay stable before the level is accepted; legal range >=2.
- LOCKOUT_CYCLES, 256: cycles after an in_valid_o pulse during which further pulses are suppressed; 0 disables lockout.
- VALID_IDX, 0: channel that drives in_valid_o.
- LONG_CYCLES, 50000: long-press threshold; used only with the optional feature.

Ports:
- wb_clk_i, input, 1: single clock.
- wb_rst_i, input, 1: reset, synchronous, active-high.
- sw_raw_i, input, NUM_SW: asynchronous switch pins, io_in[37:32].
- sw_level_o, output, NUM_SW: debounced switch level.
- sw_rise_o, output, NUM_SW: 1-cycle pulse when the debounced level goes 0->1.
- sw_fall_o, output, NUM_SW: 1-cycle pulse when the debounced level goes 1->0.
- in_valid_o, output, 1: 1-cycle operand-ready pulse to the NN.
- lockout_o, output, 1: high while the lockout counter is nonzero.
- sw_long_o, output, NUM_SW: 1-cycle long-press pulse; constant 0 unless NN_SW_LONGPRESS_EN.

Behaviour:
- Interface: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset: all of the following go to 0 on the reset edge and stay 0 while wb_rst_i=1:
  - sync flops, FSM states (ST_LO), debounce counters, lockout counter;
  - every output.
- Synchroniser: q1<=sw_raw, q2<=q1. The FSM only ever sees q2.
- Per-channel FSM, states ST_LO, WAIT_HI, ST_HI, WAIT_LO. cnt width is $clog2(DEBOUNCE_CYCLES).
  - ST_LO: q2=1 -> WAIT_HI, cnt<=0.
  - WAIT_HI, q2=0 -> ST_LO. Glitch rejected, no output change.
  - WAIT_HI, q2=1, cnt!=DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
  - WAIT_HI, q2=1, cnt==DEBOUNCE_CYCLES-1 -> ST_HI; level<=1; rise pulse asserted this cycle only.
  - ST_HI and WAIT_LO are symmetric: they produce level<=0 and a fall pulse.
- Latency: a pin change ahead of rising edge 1 that stays stable is visible on sw_level_o/sw_rise_o after edge DEBOUNCE_CYCLES+3. Any interruption shorter than that restarts the count from the stable state.
- Outputs are registered. sw_level_o equals 1 exactly when state is ST_HI or WAIT_LO.
- in_valid_o = sw_rise[VALID_IDX] & (lock_cnt==0), registered one cycle after the rise pulse.
  - Each emitted pulse loads lock_cnt<=LOCKOUT_CYCLES.
  - lock_cnt then decrements to 0 and saturates there.
  - A rise that arrives in the same cycle lock_cnt reaches 0 is accepted.
  - A suppressed rise is dropped, not queued.
- Simultaneous rises on several channels are independent. Each channel gets its own pulses.
- Reset mid-operation: in-flight debounces are aborted. A switch held through reset sees ST_LO with q2=1 after reset and produces a fresh rise DEBOUNCE_CYCLES+3 edges later. This is intended.

Optional Feature:
- Macro: NN_SW_LONGPRESS_EN.
- Defined:
  - Per-channel hold counter starts on entry to ST_HI.
  - sw_long_o[i] pulses once when the counter reaches LONG_CYCLES while the channel is still in ST_HI/WAIT_LO.
  - The counter clears on return to ST_LO.
  - Only one long pulse per press.
- Undefined: no hold counters are synthesised and sw_long_o is tied 0.

Decomposition:
- Package nn_sw_pkg: state enum sw_state_t {ST_LO, WAIT_HI, ST_HI, WAIT_LO}, default constants, a counter-width helper function.
- Sub-module nn_sw_debounce: one channel containing synchroniser, FSM, counter and optional long-press logic. Generate NUM_SW instances.
- Top level holds the lockout counter and in_valid_o.

Test Plan (all with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, LONG_CYCLES=20):
- Clean press: sw_raw[0] 0->1 before edge 1, held -> sw_level_o[0]=1 and sw_rise_o[0] pulse after edge 7; in_valid_o pulse after edge 8; lockout_o high for 8 cycles.
- Glitch: sw_raw[0] high for 3 cycles, then low -> no level change, no pulses.
- Lockout: second clean press rising 5 cycles after the first in_valid_o -> sw_rise_o pulses but in_valid_o stays 0; a press accepted once lock_cnt==0 -> in_valid_o pulses.
- Release: release a held switch -> sw_fall_o pulse and level 0 at release+7 edges; in_valid_o unaffected.
- Reset mid-debounce: assert wb_rst_i at WAIT_HI cnt=2 with switch held -> all outputs 0 during reset; rise 7 edges after reset deasserts.
- Long press (macro defined): hold 30 cycles after rise -> exactly one sw_long_o pulse, 20 cycles after entry to ST_HI; macro undefined -> sw_long_o stays 0.
